// File: rtl/bp_pkg.sv
// Shared constants for the on-chip BackPropagationNN training sequencer:
// field layout of a stored sample, target threshold and FSM state encoding.
package bp_pkg;

   localparam int unsigned BP_W       = 9;
   localparam int unsigned NUM_FIELDS = 6;

   // Field slots within a sample word; slot 5 sits in the MSBs
   localparam int unsigned FLD_X0  = 5;
   localparam int unsigned FLD_X1  = 4;
   localparam int unsigned FLD_X2  = 3;
   localparam int unsigned FLD_X3  = 2;
   localparam int unsigned FLD_DY0 = 1;
   localparam int unsigned FLD_DY1 = 0;

   // A network output is expected high when its signed target exceeds this level
   localparam int TGT_THRESHOLD = 0;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_NET_RST   = 3'd1;
   localparam state_t ST_PRESENT   = 3'd2;
   localparam state_t ST_EPOCH_END = 3'd3;
   localparam state_t ST_DONE      = 3'd4;

endpackage

// File: rtl/bp_sample_mem.sv
// Training sample store: one synchronous write port, one registered read port.
module bp_sample_mem #(
   parameter int unsigned DW    = 54,
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic          CLK,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge CLK) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/bp_train_sequencer.sv
// Training-run controller: resets the network, replays the stored sample set
// epoch by epoch and scores the network outputs until an error-free epoch.
module bp_train_sequencer
   import bp_pkg::*;
#(
   parameter int unsigned W           = BP_W,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned AW          = 8,
   parameter int unsigned HOLD_CYCLES = 24,
   parameter int unsigned RST_CYCLES  = 2,
   parameter int unsigned MAX_EPOCHS  = 16,
   parameter int unsigned EW          = 8
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                load_we,
   input  logic [AW-1:0]       load_addr,
   input  logic [6*W-1:0]      load_data,
   input  logic [AW:0]         num_samples,
   input  logic                start,
   input  logic                abort,
   output logic signed [W-1:0] x0,
   output logic signed [W-1:0] x1,
   output logic signed [W-1:0] x2,
   output logic signed [W-1:0] x3,
   output logic signed [W-1:0] desired_y0,
   output logic signed [W-1:0] desired_y1,
   output logic                net_rst,
   input  logic                y0,
   input  logic                y1,
   output logic                busy,
   output logic                done,
   output logic                converged,
   output logic [EW-1:0]       epoch_cnt,
   output logic [AW:0]         err_cnt,
   output logic [AW-1:0]       sample_idx
);

   localparam int unsigned DW = NUM_FIELDS * W;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic signed [W-1:0] TGT_LVL = W'(TGT_THRESHOLD);

   state_t        state_q, state_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [CW-1:0] num_q, num_d;
   logic [CW-1:0] run_q, run_d;
   logic [CW-1:0] err_q, err_d;
   logic [EW-1:0] epoch_q, epoch_d;
   logic          conv_q, conv_d;
   logic [DW-1:0] smp_q, smp_d;
   logic          net_rst_q, busy_q, done_q;

   logic [AW-1:0]       rd_addr_c;
   logic [DW-1:0]       rd_data;
   logic                mem_we_c;
   logic                busy_state_c;
   logic                last_c;
   logic                hold_end_c;
   logic signed [W-1:0] dy0_c, dy1_c;
   logic                err0_c, err1_c;
   logic [CW:0]         sum_c;
   logic [CW-1:0]       run_sat_c;
   logic [EW-1:0]       epoch_inc_c;

   bp_sample_mem #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .CLK     (CLK),
      .we_i    (mem_we_c),
      .waddr_i (load_addr),
      .wdata_i (load_data),
      .raddr_i (rd_addr_c),
      .rdata_o (rd_data)
   );

   // Score the sample currently presented against its thresholded targets
   always_comb begin
      dy0_c       = smp_q[FLD_DY0*W +: W];
      dy1_c       = smp_q[FLD_DY1*W +: W];
      err0_c      = y0 ^ (dy0_c > TGT_LVL);
      err1_c      = y1 ^ (dy1_c > TGT_LVL);
      sum_c       = (CW+1)'(run_q) + (CW+1)'(err0_c) + (CW+1)'(err1_c);
      run_sat_c   = sum_c[CW] ? '1 : sum_c[CW-1:0];
      epoch_inc_c = epoch_q + EW'(1);
      last_c      = ({1'b0, idx_q} == (num_q - CW'(1)));
      hold_end_c  = (hold_q == HW'(HOLD_CYCLES - 1));
   end

   always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      hold_d    = hold_q;
      idx_d     = idx_q;
      num_d     = num_q;
      run_d     = run_q;
      err_d     = err_q;
      epoch_d   = epoch_q;
      conv_d    = conv_q;
      smp_d     = smp_q;
      rd_addr_c = '0;
      mem_we_c  = 1'b0;

      busy_state_c = (state_q == ST_NET_RST) || (state_q == ST_PRESENT) ||
                     (state_q == ST_EPOCH_END);

      // Abort leaves every counter and the presented sample untouched
      if (abort && busy_state_c) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               mem_we_c = load_we;
               if (start) begin
                  epoch_d = '0;
                  err_d   = '0;
                  conv_d  = 1'b0;
                  if (num_samples == '0) begin
                     state_d = ST_DONE;
                  end else begin
                     num_d   = num_samples;
                     run_d   = '0;
                     idx_d   = '0;
                     rcnt_d  = '0;
                     hold_d  = '0;
                     state_d = ST_NET_RST;
                  end
               end
            end
            ST_NET_RST: begin
               if (rcnt_q == RW'(RST_CYCLES - 1)) begin
                  smp_d   = rd_data;
                  hold_d  = '0;
                  state_d = ST_PRESENT;
               end else begin
                  rcnt_d = rcnt_q + RW'(1);
               end
            end
            ST_PRESENT: begin
               // Prefetch the next sample, or sample 0 for the following epoch
               rd_addr_c = last_c ? '0 : idx_q + AW'(1);
               if (hold_end_c) begin
                  run_d  = run_sat_c;
                  hold_d = '0;
                  if (last_c) begin
                     state_d = ST_EPOCH_END;
                  end else begin
                     idx_d = idx_q + AW'(1);
                     smp_d = rd_data;
                  end
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
            ST_EPOCH_END: begin
               err_d   = run_q;
               epoch_d = epoch_inc_c;
               if (run_q == '0) begin
                  conv_d  = 1'b1;
                  state_d = ST_DONE;
               end else if (epoch_inc_c == EW'(MAX_EPOCHS)) begin
                  state_d = ST_DONE;
               end else begin
                  run_d   = '0;
                  idx_d   = '0;
                  hold_d  = '0;
                  smp_d   = rd_data;
                  state_d = ST_PRESENT;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= ST_IDLE;
         rcnt_q    <= '0;
         hold_q    <= '0;
         idx_q     <= '0;
         num_q     <= '0;
         run_q     <= '0;
         err_q     <= '0;
         epoch_q   <= '0;
         conv_q    <= 1'b0;
         smp_q     <= '0;
         net_rst_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rcnt_q    <= rcnt_d;
         hold_q    <= hold_d;
         idx_q     <= idx_d;
         num_q     <= num_d;
         run_q     <= run_d;
         err_q     <= err_d;
         epoch_q   <= epoch_d;
         conv_q    <= conv_d;
         smp_q     <= smp_d;
         net_rst_q <= (state_d == ST_NET_RST);
         busy_q    <= (state_d == ST_NET_RST) || (state_d == ST_PRESENT) ||
                      (state_d == ST_EPOCH_END);
         done_q    <= (state_d == ST_DONE);
      end
   end

   assign x0         = smp_q[FLD_X0*W +: W];
   assign x1         = smp_q[FLD_X1*W +: W];
   assign x2         = smp_q[FLD_X2*W +: W];
   assign x3         = smp_q[FLD_X3*W +: W];
   assign desired_y0 = smp_q[FLD_DY0*W +: W];
   assign desired_y1 = smp_q[FLD_DY1*W +: W];
   assign net_rst    = net_rst_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign converged  = conv_q;
   assign epoch_cnt  = epoch_q;
   assign err_cnt    = err_q;
   assign sample_idx = idx_q;

endmodule

// File: tb/tb_bp_train_sequencer.sv
// Scoreboard bench for bp_train_sequencer: expected run results are queued at
// start and checked on the done pulse; presented samples are checked every cycle.
module tb_bp_train_sequencer;

   localparam int unsigned W    = 9;
   localparam int unsigned AW   = 8;
   localparam int unsigned EW   = 8;
   localparam int unsigned DW   = 6 * W;
   localparam int unsigned HOLD = 24;
   localparam int unsigned RSTC = 2;
   localparam int unsigned MAXE = 16;

   typedef struct {
      int lat;
      int epochs;
      int err;
      int nrst;
      int start_p;
      int nrst_base;
      bit conv;
      bit chk_err;
   } exp_t;

   logic                CLK = 1'b0;
   logic                RST;
   logic                load_we;
   logic [AW-1:0]       load_addr;
   logic [DW-1:0]       load_data;
   logic [AW:0]         num_samples;
   logic                start;
   logic                abort;
   logic signed [W-1:0] x0, x1, x2, x3, desired_y0, desired_y1;
   logic                net_rst;
   logic                y0, y1;
   logic                busy, done, converged;
   logic [EW-1:0]       epoch_cnt;
   logic [AW:0]         err_cnt;
   logic [AW-1:0]       sample_idx;

   int            mode;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            pcnt = 0;
   int            nrst_total = 0;
   exp_t          sb[$];
   logic [DW-1:0] model [256];

   // Network stand-in: mode 0 -> y=00, mode 1 -> y0=1, mode 2 -> both high
   assign y0 = (mode != 0);
   assign y1 = (mode == 2);

   always #5 CLK = ~CLK;
   always @(posedge CLK) pcnt <= pcnt + 1;

   bp_train_sequencer #(
      .W(W), .DEPTH(256), .AW(AW), .HOLD_CYCLES(HOLD), .RST_CYCLES(RSTC),
      .MAX_EPOCHS(MAXE), .EW(EW)
   ) dut (
      .CLK(CLK), .RST(RST), .load_we(load_we), .load_addr(load_addr),
      .load_data(load_data), .num_samples(num_samples), .start(start),
      .abort(abort), .x0(x0), .x1(x1), .x2(x2), .x3(x3),
      .desired_y0(desired_y0), .desired_y1(desired_y1), .net_rst(net_rst),
      .y0(y0), .y1(y1), .busy(busy), .done(done), .converged(converged),
      .epoch_cnt(epoch_cnt), .err_cnt(err_cnt), .sample_idx(sample_idx)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(input int i);
      return {9'(i + 1), 9'(-(i + 2)), 9'(10 * i), 9'(i - 100), 9'(100), 9'(-50)};
   endfunction

   function automatic int model_err(input int n, input int m);
      int e = 0;
      logic signed [W-1:0] d0, d1;
      logic ym0, ym1;
      ym0 = (m != 0);
      ym1 = (m == 2);
      for (int i = 0; i < n; i++) begin
         d0 = model[i][W +: W];
         d1 = model[i][0 +: W];
         e += int'(ym0 != (d0 > 0)) + int'(ym1 != (d1 > 0));
      end
      return e;
   endfunction

   // Monitor: presented sample vs model, and run results on the done pulse
   always @(negedge CLK) begin
      exp_t e;
      if (net_rst) nrst_total++;
      if (busy && !net_rst)
         check_eq("x_sample", 64'({x0, x1, x2, x3, desired_y0, desired_y1}),
                  64'(model[sample_idx]));
      if (done) begin
         if (sb.size() == 0) begin
            check_eq("spurious_done", 64'(done), 64'd0);
         end else begin
            e = sb.pop_front();
            check_eq("done_latency", 64'(pcnt - e.start_p), 64'(e.lat));
            check_eq("converged", 64'(converged), 64'(e.conv));
            check_eq("epoch_cnt", 64'(epoch_cnt), 64'(e.epochs));
            if (e.chk_err) check_eq("err_cnt", 64'(err_cnt), 64'(e.err));
            check_eq("net_rst_cycles", 64'(nrst_total - e.nrst_base), 64'(e.nrst));
            check_eq("busy_at_done", 64'(busy), 64'd0);
         end
      end
   end

   task automatic load_sample(input int i);
      @(posedge CLK); #1;
      load_we   = 1'b1;
      load_addr = AW'(i);
      load_data = mk(i);
      model[i]  = mk(i);
      @(posedge CLK); #1;
      load_we = 1'b0;
   endtask

   task automatic start_run(input int n, input int m, input bit chk_err);
      exp_t e;
      int   er;
      @(posedge CLK); #1;
      mode        = m;
      num_samples = (AW+1)'(n);
      start       = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      er = model_err(n, m);
      e.chk_err   = chk_err;
      e.start_p   = pcnt;
      e.nrst_base = nrst_total;
      if (n == 0) begin
         e.epochs = 0; e.conv = 1'b0; e.err = 0; e.lat = 0; e.nrst = 0;
      end else begin
         e.conv   = (er == 0);
         e.epochs = (er == 0) ? 1 : int'(MAXE);
         e.err    = er;
         e.lat    = int'(RSTC) + e.epochs * (n * int'(HOLD) + 1);
         e.nrst   = int'(RSTC);
      end
      sb.push_back(e);
   endtask

   task automatic wait_done(input int limit);
      int k = 0;
      while (sb.size() != 0 && k < limit) begin
         @(posedge CLK);
         k++;
      end
      check_eq("run_completed", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   initial begin
      bit found;
      RST = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
      num_samples = '0; start = 1'b0; abort = 1'b0; mode = 1;
      repeat (3) @(posedge CLK);
      #1;
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_net_rst", 64'(net_rst), 64'd0);
      check_eq("rst_outputs", 64'({converged, epoch_cnt, err_cnt, sample_idx, x0, desired_y1}), 64'd0);
      RST = 1'b1;

      for (int i = 0; i < 3; i++) load_sample(i);

      // Async reset in the middle of PRESENT
      start_run(3, 1, 1'b1);
      repeat (39) @(posedge CLK);
      #2 RST = 1'b0;
      #1;
      check_eq("midrst_busy", 64'(busy), 64'd0);
      check_eq("midrst_net_rst", 64'(net_rst), 64'd0);
      check_eq("midrst_outputs", 64'({x0, x1, desired_y0, sample_idx, epoch_cnt}), 64'd0);
      sb.delete();
      @(posedge CLK); #1 RST = 1'b1;
      repeat (10) @(posedge CLK);
      #1;
      check_eq("idle_after_rst", 64'({busy, net_rst}), 64'd0);

      for (int i = 0; i < 3; i++) load_sample(i);

      // Converging run with start/load_we poked while busy
      start_run(3, 1, 1'b1);
      repeat (29) @(posedge CLK);
      #1;
      check_eq("idx_at_poke", 64'(sample_idx), 64'd1);
      load_we = 1'b1; load_addr = AW'(2); load_data = '1;
      start = 1'b1; num_samples = (AW+1)'(5);
      @(posedge CLK); #1;
      load_we = 1'b0; start = 1'b0;
      wait_done(3000);

      // Non-converging runs: y0 wrong every sample, then y1 wrong every sample
      start_run(3, 0, 1'b1);
      wait_done(3000);
      start_run(2, 2, 1'b1);
      wait_done(3000);

      // Empty sample set
      start_run(0, 1, 1'b0);
      wait_done(10);

      // Abort during epoch 2, sample 1
      start_run(3, 0, 1'b1);
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
         @(posedge CLK); #1;
         if (epoch_cnt == EW'(1) && sample_idx == AW'(1)) found = 1'b1;
      end
      check_eq("abort_point_reached", 64'(found), 64'd1);
      abort = 1'b1;
      @(posedge CLK); #1;
      abort = 1'b0;
      check_eq("abort_busy", 64'(busy), 64'd0);
      check_eq("abort_net_rst", 64'(net_rst), 64'd0);
      check_eq("abort_epoch_hold", 64'(epoch_cnt), 64'd1);
      sb.delete();
      repeat (4) @(posedge CLK);
      #1;
      check_eq("abort_idle", 64'({busy, done}), 64'd0);
      start_run(3, 1, 1'b1);
      wait_done(3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bp_train_sequencer.md
Name: bp_train_sequencer

Overview:
Training-run controller for BackPropagationNN. Holds a loaded sample set of 4 inputs and 2 targets per sample. On start, it pulses the network reset, then presents every sample for a fixed hold window and samples the network's y0/y1 at the end of that window. It counts mismatches per epoch and repeats epochs until one is error-free or the epoch limit is reached. It replaces file-driven stimulus with an on-chip, repeatable training schedule.

Parameters:
W, 9, signed width of every x and desired_y field
DEPTH, 256, sample memory entries
AW, 8, address width (log2 DEPTH)
HOLD_CYCLES, 24, CLK cycles each sample is presented
RST_CYCLES, 2, cycles net_rst is held high at run start
MAX_EPOCHS, 16, epoch limit (≥1)
EW, 8, epoch_cnt width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-low reset
load_we  in  1  write one sample into memory (ignored while busy)
load_addr  in  AW  write address
load_data  in  6*W  {x0,x1,x2,x3,desired_y0,desired_y1}, x0 in MSBs
num_samples  in  AW+1  samples per epoch, sampled on start
start  in  1  begin run (ignored while busy)
abort  in  1  stop run, return to IDLE
x0,x1,x2,x3  out  W each  network inputs, signed, registered
desired_y0,desired_y1  out  W each  network targets, signed, registered
net_rst  out  1  active-high reset to network
y0,y1  in  1 each  network outputs
busy  out  1  run in progress
done  out  1  one-cycle pulse at run completion
converged  out  1  last run ended with a zero-error epoch
epoch_cnt  out  EW  epochs completed in current/last run
err_cnt  out  AW+1  mismatches in last completed epoch
sample_idx  out  AW  index of sample being presented

Behaviour:
- Reset (RST=0, async): state IDLE; all outputs 0; memory contents undefined.
- Target bit per output: tgt = (desired_y > 0), signed compare; mismatch when y != tgt. Both outputs are checked, so each sample adds 0, 1 or 2 errors. The running error count saturates at 2^(AW+1)-1.
- States: IDLE, NET_RST, PRESENT, EPOCH_END, DONE.
- IDLE: start=1 with num_samples=0 → DONE, converged=0, epoch_cnt=0. start=1 otherwise → latch num_samples, clear epoch_cnt/err_cnt/converged, busy=1 → NET_RST.
- NET_RST: net_rst=1 for exactly RST_CYCLES cycles. Memory read of sample 0 completes so that x/desired hold sample 0 on the first PRESENT cycle. Then → PRESENT.
- PRESENT: x/desired hold sample sample_idx for HOLD_CYCLES cycles.
  - On the cycle with hold counter = HOLD_CYCLES-1, y0/y1 are compared and the running count is updated.
  - If not the last sample, the next sample appears on the following cycle, back-to-back with no gap; sample_idx increments.
  - If it is the last sample (idx = num_samples-1) → EPOCH_END.
- EPOCH_END (1 cycle): outputs hold the last sample; err_cnt ← running count; epoch_cnt+1.
  - If running count = 0 → converged=1, → DONE.
  - Else if epoch_cnt+1 = MAX_EPOCHS → DONE.
  - Else clear running count, sample_idx=0, → PRESENT with sample 0. There is no net_rst between epochs.
- DONE (1 cycle): done=1, busy=0 → IDLE. converged, epoch_cnt and err_cnt hold until the next accepted start.
- Epoch length: num_samples*HOLD_CYCLES + 1 cycles.
- abort (any busy state, priority over all transitions) → IDLE next cycle: busy=0, net_rst=0, no done pulse, counters hold.
- start while busy: ignored. load_we while busy: ignored (no write).
- Async reset mid-run: immediate return to reset values; net_rst drops to 0.

Decomposition:
- Package bp_pkg: W, state enum, load_data field offsets, localparam for tgt compare.
- Sub-module bp_sample_mem: DEPTH×6W, one sync write port, one sync read port.
- The FSM, counters and compare logic live in the top.

Test Plan:
- Reset mid-PRESENT (RST low at cycle 40) → all outputs 0 within the same cycle; busy=0; after release, no activity until start.
- Load 3 samples with desired_y0=+100/desired_y1=-50, bench model drives y0=1/y1=0; start with num_samples=3 → net_rst high 2 cycles; each sample held 24 cycles; one epoch; done pulse at cycle 2+72+1+1; converged=1, epoch_cnt=1, err_cnt=0.
- Same load, model always drives y0=0/y1=0 → 16 epochs; done with converged=0, epoch_cnt=16, err_cnt=3.
- num_samples=0, start → done pulse one cycle later; converged=0, epoch_cnt=0; net_rst never asserted.
- abort at epoch 2, sample 1 → busy=0 next cycle, no done pulse; a second start 5 cycles later runs normally.
- start and load_we asserted during PRESENT → state unchanged; memory readback after the run shows the original data.
